lockin_acquisition_sequencer: RTL

Sequences a complete lock-in photon-counting acquisition for the fluorescence front end. It drives the modulated light source and gates PMT pulse counting into "source on" and "source off" bins, blanking the start of each half-period. It runs a programmed number of frames and delivers each frame's on/off counts and signed difference over a valid/ready handshake. It sits between the synchronized PMT pulse strobe and the readout/host logic.

---
 rtl/lockin_acquisition_sequencer.sv | 287 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/lockin_acquisition_sequencer.sv
// lockin_acquisition_sequencer
//   Runs a lock-in photon-counting acquisition. It drives the modulated light
//   source and bins synchronized PMT pulses into "source on" and "source off"
//   counters, ignoring the first cfg_blank clocks of every half-period. Each
//   frame's counts and their signed difference go out over valid/ready.
// Ports:
//   clock_50_mhz, reset_n        : clock, synchronous active-low reset
//   start, abort                 : acquisition control
//   cfg_half_period/blank/cycles/frames : configuration, latched on start
//   pulse_in                     : one-cycle PMT strobe (already synchronized)
//   light_source_pin             : registered light source drive
//   busy, cfg_err, done          : status
//   frame_valid/frame_ready      : result handshake
//   frame_add/sub/diff/index     : result payload
module lockin_acquisition_sequencer #(
  parameter int COUNT_W = 32,
  parameter int PER_W   = 32
) (
  input  logic               clock_50_mhz,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [PER_W-1:0]   cfg_half_period,
  input  logic [15:0]        cfg_blank,
  input  logic [15:0]        cfg_cycles,
  input  logic [15:0]        cfg_frames,
  input  logic               pulse_in,
  output logic               light_source_pin,
  output logic               busy,
  output logic               cfg_err,
  output logic               frame_valid,
  input  logic               frame_ready,
  output logic [COUNT_W-1:0] frame_add,
  output logic [COUNT_W-1:0] frame_sub,
  output logic [COUNT_W:0]   frame_diff,
  output logic [15:0]        frame_index,
  output logic               done
);

  // Common width for comparing the 16-bit blank against the PER_W timer.
  localparam int CMP_W = (PER_W > 16) ? PER_W : 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t             state_r, state_s;
  logic               light_r, light_s;
  logic [PER_W-1:0]   phase_r, phase_s;
  logic [16:0]        half_cnt_r, half_cnt_s;
  logic [15:0]        frame_cnt_r, frame_cnt_s;
  logic [COUNT_W-1:0] add_cnt_r, add_cnt_s;
  logic [COUNT_W-1:0] sub_cnt_r, sub_cnt_s;
  logic [PER_W-1:0]   half_cfg_r, half_cfg_s;
  logic [15:0]        blank_cfg_r, blank_cfg_s;
  logic [15:0]        cycles_cfg_r, cycles_cfg_s;
  logic [15:0]        frames_cfg_r, frames_cfg_s;
  logic [COUNT_W-1:0] out_add_r, out_add_s;
  logic [COUNT_W-1:0] out_sub_r, out_sub_s;
  logic [COUNT_W:0]   out_diff_r, out_diff_s;
  logic [15:0]        out_index_r, out_index_s;
  logic               valid_r, valid_s;
  logic               cfg_err_r, cfg_err_s;
  logic               done_r, done_s;
  logic               busy_r, busy_s;

  logic               cfg_ok_s;
  logic               count_en_s;
  logic [COUNT_W-1:0] add_inc_s, sub_inc_s;
  logic               phase_wrap_s, last_half_s, last_frame_s;
  logic               handshake_s, out_free_s;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    if (&v) begin
      sat_inc = v;
    end else begin
      sat_inc = v + COUNT_W'(1'b1);
    end
  endfunction

  // Difference computed one bit wider so it cannot overflow.
  function automatic logic [COUNT_W:0] signed_diff(input logic [COUNT_W-1:0] a,
                                                   input logic [COUNT_W-1:0] b);
    signed_diff = {1'b0, a} - {1'b0, b};
  endfunction

  assign cfg_ok_s     = (cfg_half_period >= PER_W'(2'd2)) &&
                        (CMP_W'(cfg_blank) < CMP_W'(cfg_half_period)) &&
                        (cfg_cycles != 16'd0) && (cfg_frames != 16'd0);
  assign count_en_s   = pulse_in && (CMP_W'(phase_r) >= CMP_W'(blank_cfg_r));
  assign add_inc_s    = (count_en_s && light_r)  ? sat_inc(add_cnt_r) : add_cnt_r;
  assign sub_inc_s    = (count_en_s && !light_r) ? sat_inc(sub_cnt_r) : sub_cnt_r;
  assign phase_wrap_s = (phase_r == half_cfg_r - PER_W'(1'b1));
  // Half-periods are numbered from 0 within a frame; the last one is odd, so off.
  assign last_half_s  = (half_cnt_r == {cycles_cfg_r, 1'b0} - 17'd1);
  assign last_frame_s = (frame_cnt_r == frames_cfg_r - 16'd1);
  assign handshake_s  = valid_r && frame_ready;
  assign out_free_s   = !valid_r || frame_ready;

  // Next-state, counter and output-register logic for the acquisition FSM.
  always_comb begin
    state_s      = state_r;
    light_s      = light_r;
    phase_s      = phase_r;
    half_cnt_s   = half_cnt_r;
    frame_cnt_s  = frame_cnt_r;
    add_cnt_s    = add_cnt_r;
    sub_cnt_s    = sub_cnt_r;
    half_cfg_s   = half_cfg_r;
    blank_cfg_s  = blank_cfg_r;
    cycles_cfg_s = cycles_cfg_r;
    frames_cfg_s = frames_cfg_r;
    out_add_s    = out_add_r;
    out_sub_s    = out_sub_r;
    out_diff_s   = out_diff_r;
    out_index_s  = out_index_r;
    valid_s      = handshake_s ? 1'b0 : valid_r;
    cfg_err_s    = 1'b0;
    done_s       = 1'b0;
    if (abort) begin
      state_s     = ST_IDLE;
      light_s     = 1'b0;
      phase_s     = {PER_W{1'b0}};
      half_cnt_s  = 17'd0;
      frame_cnt_s = 16'd0;
      add_cnt_s   = {COUNT_W{1'b0}};
      sub_cnt_s   = {COUNT_W{1'b0}};
      valid_s     = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          light_s     = 1'b0;
          phase_s     = {PER_W{1'b0}};
          half_cnt_s  = 17'd0;
          frame_cnt_s = 16'd0;
          add_cnt_s   = {COUNT_W{1'b0}};
          sub_cnt_s   = {COUNT_W{1'b0}};
          if (start && cfg_ok_s) begin
            half_cfg_s   = cfg_half_period;
            blank_cfg_s  = cfg_blank;
            cycles_cfg_s = cfg_cycles;
            frames_cfg_s = cfg_frames;
            state_s      = ST_RUN;
            light_s      = 1'b1;
          end else if (start) begin
            cfg_err_s = 1'b1;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          add_cnt_s = add_inc_s;
          sub_cnt_s = sub_inc_s;
          if (phase_wrap_s) begin
            phase_s    = {PER_W{1'b0}};
            light_s    = !light_r;
            half_cnt_s = half_cnt_r + 17'd1;
            if (last_half_s && out_free_s) begin
              // Final cycle's pulse is already folded into add/sub_inc_s.
              half_cnt_s  = 17'd0;
              out_add_s   = add_inc_s;
              out_sub_s   = sub_inc_s;
              out_diff_s  = signed_diff(add_inc_s, sub_inc_s);
              out_index_s = frame_cnt_r;
              valid_s     = 1'b1;
              add_cnt_s   = {COUNT_W{1'b0}};
              sub_cnt_s   = {COUNT_W{1'b0}};
              if (last_frame_s) begin
                state_s = ST_DONE;
                light_s = 1'b0;
              end else begin
                frame_cnt_s = frame_cnt_r + 16'd1;
              end
            end else if (last_half_s) begin
              // Result register still held: park the finished counts.
              half_cnt_s = 17'd0;
              state_s    = ST_STALL;
              light_s    = 1'b0;
            end else begin
              state_s = ST_RUN;
            end
          end else begin
            phase_s = phase_r + PER_W'(1'b1);
          end
        end
        ST_STALL: begin
          light_s = 1'b0;
          if (handshake_s) begin
            out_add_s   = add_cnt_r;
            out_sub_s   = sub_cnt_r;
            out_diff_s  = signed_diff(add_cnt_r, sub_cnt_r);
            out_index_s = frame_cnt_r;
            valid_s     = 1'b1;
            add_cnt_s   = {COUNT_W{1'b0}};
            sub_cnt_s   = {COUNT_W{1'b0}};
            phase_s     = {PER_W{1'b0}};
            half_cnt_s  = 17'd0;
            if (last_frame_s) begin
              state_s = ST_DONE;
            end else begin
              state_s     = ST_RUN;
              light_s     = 1'b1;
              frame_cnt_s = frame_cnt_r + 16'd1;
            end
          end else begin
            state_s = ST_STALL;
          end
        end
        ST_DONE: begin
          light_s = 1'b0;
          if (handshake_s) begin
            done_s  = 1'b1;
            state_s = ST_IDLE;
          end else begin
            state_s = ST_DONE;
          end
        end
        default: begin
          state_s = ST_IDLE;
          light_s = 1'b0;
          valid_s = 1'b0;
        end
      endcase
    end
    busy_s = (state_s != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock_50_mhz) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      light_r      <= 1'b0;
      phase_r      <= {PER_W{1'b0}};
      half_cnt_r   <= 17'd0;
      frame_cnt_r  <= 16'd0;
      add_cnt_r    <= {COUNT_W{1'b0}};
      sub_cnt_r    <= {COUNT_W{1'b0}};
      half_cfg_r   <= {PER_W{1'b0}};
      blank_cfg_r  <= 16'd0;
      cycles_cfg_r <= 16'd0;
      frames_cfg_r <= 16'd0;
      out_add_r    <= {COUNT_W{1'b0}};
      out_sub_r    <= {COUNT_W{1'b0}};
      out_diff_r   <= {(COUNT_W+1){1'b0}};
      out_index_r  <= 16'd0;
      valid_r      <= 1'b0;
      cfg_err_r    <= 1'b0;
      done_r       <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      light_r      <= light_s;
      phase_r      <= phase_s;
      half_cnt_r   <= half_cnt_s;
      frame_cnt_r  <= frame_cnt_s;
      add_cnt_r    <= add_cnt_s;
      sub_cnt_r    <= sub_cnt_s;
      half_cfg_r   <= half_cfg_s;
      blank_cfg_r  <= blank_cfg_s;
      cycles_cfg_r <= cycles_cfg_s;
      frames_cfg_r <= frames_cfg_s;
      out_add_r    <= out_add_s;
      out_sub_r    <= out_sub_s;
      out_diff_r   <= out_diff_s;
      out_index_r  <= out_index_s;
      valid_r      <= valid_s;
      cfg_err_r    <= cfg_err_s;
      done_r       <= done_s;
      busy_r       <= busy_s;
    end
  end

  assign light_source_pin = light_r;
  assign busy             = busy_r;
  assign cfg_err          = cfg_err_r;
  assign frame_valid      = valid_r;
  assign frame_add        = out_add_r;
  assign frame_sub        = out_sub_r;
  assign frame_diff       = out_diff_r;
  assign frame_index      = out_index_r;
  assign done             = done_r;

endmodule
